conv_mult_stage_gated: RTL and testbench



---
 rtl/conv_pkg.sv | 20 ++
 rtl/conv_mult_lane.sv | 80 ++++++++
 rtl/conv_mult_stage_gated.sv | 105 ++++++++++
 tb/tb_conv_mult_stage_gated.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants for the gated convolution multiply stage.
//   LANES_DEF / IN_W_DEF / ACC_LEN_DEF : default lane count, operand width, group length
//   MODE_PASS / MODE_ACC               : encoding of the latched acc_mode bit
//   calc_acc_w()                       : result width that cannot overflow over one group
package conv_pkg;

   localparam int unsigned LANES_DEF   = 6;
   localparam int unsigned IN_W_DEF    = 6;
   localparam int unsigned ACC_LEN_DEF = 4;

   localparam logic MODE_PASS = 1'b0;
   localparam logic MODE_ACC  = 1'b1;

   // Full product width plus enough headroom for ACC_LEN summed products.
   function automatic int unsigned calc_acc_w(input int unsigned in_w,
                                              input int unsigned acc_len);
      return 2 * in_w + $clog2(acc_len);
   endfunction

endpackage

// File: rtl/conv_mult_lane.sv
// One multiply lane: gated operand registers (S1) and product load/accumulate register (S2).
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : beat accepted into S1 this cycle
//   a, b, en   : signed operands and lane enable for the incoming beat
//   adv        : S1 advances into S2 this cycle
//   add        : on adv, add the product to the held sum instead of loading it
//   acc        : S2 result, ACC_W bits signed
//   gated      : S2 gated flag (AND of gate flags across an accumulated group)
module conv_mult_lane
   import conv_pkg::*;
#(
   parameter int unsigned IN_W    = IN_W_DEF,
   parameter int unsigned ACC_LEN = ACC_LEN_DEF,
   localparam int unsigned PROD_W = 2 * IN_W,
   localparam int unsigned ACC_W  = calc_acc_w(IN_W, ACC_LEN)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [IN_W-1:0]  a,
   input  logic [IN_W-1:0]  b,
   input  logic             en,
   input  logic             adv,
   input  logic             add,
   output logic [ACC_W-1:0] acc,
   output logic             gated
);

   logic [IN_W-1:0]   a_q, b_q;
   logic              gate_q;
   logic              gate;
   logic [PROD_W-1:0] a_ext, b_ext, prod;
   logic [ACC_W-1:0]  prod_ext;
   logic [ACC_W-1:0]  acc_q;
   logic              gated_q;

   assign gate = !en | (a == '0) | (b == '0);

   // A gated beat leaves the operand registers untouched so the multiplier inputs stay static.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         gate_q <= 1'b0;
      end else if (load) begin
         gate_q <= gate;
         if (!gate) begin
            a_q <= a;
            b_q <= b;
         end
      end
   end

   always_comb begin
      a_ext = {{IN_W{a_q[IN_W-1]}}, a_q};
      b_ext = {{IN_W{b_q[IN_W-1]}}, b_q};
      // The stale held operands are masked out by the gate flag.
      prod     = gate_q ? '0 : a_ext * b_ext;
      prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q   <= '0;
         gated_q <= 1'b0;
      end else if (adv) begin
         if (add) begin
            acc_q   <= acc_q + prod_ext;
            gated_q <= gated_q & gate_q;
         end else begin
            acc_q   <= prod_ext;
            gated_q <= gate_q;
         end
      end
   end

   assign acc   = acc_q;
   assign gated = gated_q;

endmodule

// File: rtl/conv_mult_stage_gated.sv
// Two-stage valid/ready multiply stage with per-lane operand gating and an optional
// accumulate mode that sums ACC_LEN beats per lane into one result.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : input beat handshake
//   in_a, in_b           : LANES packed signed operands, lane i at [i*IN_W +: IN_W]
//   lane_en              : per-lane enable, 0 gates the lane
//   acc_mode             : 0 = pass each product, 1 = accumulate ACC_LEN beats
//   out_valid / out_ready: result handshake
//   out_data             : LANES packed signed results, lane i at [i*ACC_W +: ACC_W]
//   out_gated            : per-lane gated indication for the presented result
module conv_mult_stage_gated
   import conv_pkg::*;
#(
   parameter int unsigned LANES   = LANES_DEF,
   parameter int unsigned IN_W    = IN_W_DEF,
   parameter int unsigned ACC_LEN = ACC_LEN_DEF,
   localparam int unsigned PROD_W = 2 * IN_W,
   localparam int unsigned ACC_W  = calc_acc_w(IN_W, ACC_LEN)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*IN_W-1:0]  in_a,
   input  logic [LANES*IN_W-1:0]  in_b,
   input  logic [LANES-1:0]       lane_en,
   input  logic                   acc_mode,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*ACC_W-1:0] out_data,
   output logic [LANES-1:0]       out_gated
);

   localparam int unsigned CNT_W = $clog2(ACC_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

   logic             s1_valid_q;
   logic             s1_mode_q;
   logic             grp_mode_q;
   logic [CNT_W-1:0] cnt_q;
   logic             out_valid_q;

   logic accept, s1_adv, eff_mode, last, add;

   assign s1_adv   = s1_valid_q & (!out_valid_q | out_ready);
   assign in_ready = !s1_valid_q | s1_adv;
   assign accept   = in_valid & in_ready;

   // A group's mode is fixed by its first beat; later beats follow it regardless of their bit.
   assign eff_mode = (cnt_q == '0) ? s1_mode_q : grp_mode_q;
   assign last     = (eff_mode == MODE_PASS) | (cnt_q == CNT_LAST);
   assign add      = (eff_mode == MODE_ACC) & (cnt_q != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_mode_q  <= MODE_PASS;
      end else if (accept) begin
         s1_valid_q <= 1'b1;
         s1_mode_q  <= acc_mode;
      end else if (s1_adv) begin
         s1_valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grp_mode_q  <= MODE_PASS;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
      end else if (s1_adv) begin
         if (cnt_q == '0) begin
            grp_mode_q <= s1_mode_q;
         end
         if (eff_mode == MODE_ACC) begin
            cnt_q <= last ? '0 : cnt_q + 1'b1;
         end
         // Partial sums clear out_valid; the previous result was already taken.
         out_valid_q <= last;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid = out_valid_q;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      conv_mult_lane #(
         .IN_W    (IN_W),
         .ACC_LEN (ACC_LEN)
      ) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .load  (accept),
         .a     (in_a[i*IN_W +: IN_W]),
         .b     (in_b[i*IN_W +: IN_W]),
         .en    (lane_en[i]),
         .adv   (s1_adv),
         .add   (add),
         .acc   (out_data[i*ACC_W +: ACC_W]),
         .gated (out_gated[i])
      );
   end

endmodule

// File: tb/tb_conv_mult_stage_gated.sv
// Directed self-checking bench for conv_mult_stage_gated (LANES=6, IN_W=6, ACC_LEN=4).
module tb_conv_mult_stage_gated;

   localparam int unsigned LANES   = 6;
   localparam int unsigned IN_W    = 6;
   localparam int unsigned ACC_LEN = 4;
   localparam int unsigned ACC_W   = 14;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   in_valid;
   logic                   in_ready;
   logic [LANES*IN_W-1:0]  in_a;
   logic [LANES*IN_W-1:0]  in_b;
   logic [LANES-1:0]       lane_en;
   logic                   acc_mode;
   logic                   out_valid;
   logic                   out_ready;
   logic [LANES*ACC_W-1:0] out_data;
   logic [LANES-1:0]       out_gated;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   conv_mult_stage_gated #(
      .LANES   (LANES),
      .IN_W    (IN_W),
      .ACC_LEN (ACC_LEN)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .lane_en   (lane_en),
      .acc_mode  (acc_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_gated (out_gated)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lane(input int i, input int a, input int b);
      logic [IN_W-1:0] av, bv;
      av = a[IN_W-1:0];
      bv = b[IN_W-1:0];
      in_a[i*IN_W +: IN_W] = av;
      in_b[i*IN_W +: IN_W] = bv;
   endtask

   task automatic clear_lanes();
      in_a = '0;
      in_b = '0;
   endtask

   function automatic integer lane_out(input int i);
      logic signed [ACC_W-1:0] v;
      v = out_data[i*ACC_W +: ACC_W];
      return integer'(v);
   endfunction

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      acc_mode  = 1'b0;
      lane_en   = '1;
      clear_lanes();
      #13;
      total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
      else passed++;
      total++; if (out_data !== '0) $display("FAIL reset_out_data got %h want 0", out_data);
      else passed++;
      total++; if (out_gated !== '0) $display("FAIL reset_out_gated got %b want 0", out_gated);
      else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_pass();
      clear_lanes();
      set_lane(0, -3, 5);
      set_lane(1, 2, 3);
      set_lane(2, 4, -2);
      acc_mode = 1'b0;
      in_valid = 1'b1;
      total++; if (in_ready !== 1'b1) $display("FAIL pass_in_ready got %b want 1", in_ready);
      else passed++;
      tick();  // beat captured into S1
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b0) $display("FAIL pass_early_valid got %b want 0", out_valid);
      else passed++;
      tick();  // result reaches the output register
      total++; if (out_valid !== 1'b1) $display("FAIL pass_valid got %b want 1", out_valid);
      else passed++;
      total++; if (out_data[ACC_W-1:0] !== 14'h3FF1)
         $display("FAIL pass_lane0 got %h want 3ff1", out_data[ACC_W-1:0]);
      else passed++;
      total++; if (lane_out(1) !== 6) $display("FAIL pass_lane1 got %0d want 6", lane_out(1));
      else passed++;
      total++; if (lane_out(2) !== -8) $display("FAIL pass_lane2 got %0d want -8", lane_out(2));
      else passed++;
      total++; if (out_gated !== 6'b111000)
         $display("FAIL pass_gated got %b want 111000", out_gated);
      else passed++;
      tick();
      total++; if (out_valid !== 1'b0) $display("FAIL pass_drop got %b want 0", out_valid);
      else passed++;
   endtask

   // Lane 1 still holds a=2, b=3 from the pass test.
   task automatic test_gating();
      clear_lanes();
      set_lane(0, 1, 1);
      set_lane(1, 0, 7);
      acc_mode = 1'b0;
      in_valid = 1'b1;
      tick();
      lane_en[1] = 1'b0;
      set_lane(1, 9, 7);
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         total++; if (out_valid !== 1'b1) $display("FAIL gate%0d_valid got %b want 1", k, out_valid);
         else passed++;
         total++; if (lane_out(1) !== 0) $display("FAIL gate%0d_lane1 got %0d want 0", k, lane_out(1));
         else passed++;
         total++; if (out_gated[1] !== 1'b1)
            $display("FAIL gate%0d_flag got %b want 1", k, out_gated[1]);
         else passed++;
         total++; if (dut.g_lane[1].u_lane.a_q !== 6'd2)
            $display("FAIL gate%0d_a_hold got %0d want 2", k, dut.g_lane[1].u_lane.a_q);
         else passed++;
         total++; if (dut.g_lane[1].u_lane.b_q !== 6'd3)
            $display("FAIL gate%0d_b_hold got %0d want 3", k, dut.g_lane[1].u_lane.b_q);
         else passed++;
         tick();
      end
      lane_en = '1;
      tick();
   endtask

   task automatic acc_group(input int a, input int b, input integer expv, input string nm);
      clear_lanes();
      set_lane(0, a, b);
      acc_mode = 1'b1;
      in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         total++; if (out_valid !== 1'b0)
            $display("FAIL %s_partial%0d got %b want 0", nm, k, out_valid);
         else passed++;
      end
      in_valid = 1'b0;
      tick();
      total++; if (out_valid !== 1'b1) $display("FAIL %s_valid got %b want 1", nm, out_valid);
      else passed++;
      total++; if (lane_out(0) !== expv)
         $display("FAIL %s_sum got %0d want %0d", nm, lane_out(0), expv);
      else passed++;
      total++; if (out_gated !== 6'b111110)
         $display("FAIL %s_gated got %b want 111110", nm, out_gated);
      else passed++;
      tick();
      total++; if (out_valid !== 1'b0) $display("FAIL %s_drop got %b want 0", nm, out_valid);
      else passed++;
   endtask

   task automatic test_accumulate();
      acc_group(-32, -32, 4096, "acc_neg");
      acc_group(31, 31, 3844, "acc_pos");
   endtask

   task automatic test_backpressure();
      int sent = 0;
      int got  = 0;
      integer expv = 1;
      acc_mode = 1'b0;
      clear_lanes();
      for (int cyc = 0; cyc < 30 && got < 6; cyc++) begin
         out_ready = !(cyc >= 2 && cyc <= 4);
         if (sent < 6) begin
            in_valid = 1'b1;
            set_lane(0, sent + 1, 1);
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (cyc == 2) begin
            total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got %b want 0", in_ready);
            else passed++;
         end
         if (out_valid && out_ready) begin
            total++; if (lane_out(0) !== expv)
               $display("FAIL bp_order got %0d want %0d", lane_out(0), expv);
            else passed++;
            expv++;
            got++;
         end
         if (in_valid && in_ready) sent++;
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      total++; if (got !== 6) $display("FAIL bp_count got %0d want 6", got);
      else passed++;
      total++; if (sent !== 6) $display("FAIL bp_sent got %0d want 6", sent);
      else passed++;
      total++; if (out_valid !== 1'b0) $display("FAIL bp_dup got %b want 0", out_valid);
      else passed++;
   endtask

   task automatic test_mode_change();
      clear_lanes();
      in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         acc_mode = (k == 0);
         set_lane(0, k + 1, 2);
         tick();
         total++; if (out_valid !== 1'b0) $display("FAIL mode_partial%0d got %b want 0", k, out_valid);
         else passed++;
      end
      acc_mode = 1'b0;
      set_lane(0, 3, 3);
      tick();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1) $display("FAIL mode_grp_valid got %b want 1", out_valid);
      else passed++;
      total++; if (lane_out(0) !== 20) $display("FAIL mode_grp_sum got %0d want 20", lane_out(0));
      else passed++;
      tick();
      total++; if (out_valid !== 1'b1) $display("FAIL mode_pass_valid got %b want 1", out_valid);
      else passed++;
      total++; if (lane_out(0) !== 9) $display("FAIL mode_pass_data got %0d want 9", lane_out(0));
      else passed++;
      tick();
      total++; if (out_valid !== 1'b0) $display("FAIL mode_drop got %b want 0", out_valid);
      else passed++;
   endtask

   task automatic test_reset_mid_group();
      clear_lanes();
      set_lane(0, 5, 5);
      acc_mode = 1'b1;
      in_valid = 1'b1;
      tick();
      tick();
      in_valid = 1'b0;
      total++; if (lane_out(0) !== 25) $display("FAIL rmid_partial got %0d want 25", lane_out(0));
      else passed++;
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) $display("FAIL rmid_valid got %b want 0", out_valid);
      else passed++;
      total++; if (out_data !== '0) $display("FAIL rmid_data got %h want 0", out_data);
      else passed++;
      total++; if (out_gated !== '0) $display("FAIL rmid_gated got %b want 0", out_gated);
      else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL rmid_in_ready got %b want 1", in_ready);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      set_lane(0, 1, 1);
      in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         total++; if (out_valid !== 1'b0) $display("FAIL rmid_partial%0d got %b want 0", k, out_valid);
         else passed++;
      end
      in_valid = 1'b0;
      tick();
      total++; if (out_valid !== 1'b1) $display("FAIL rmid_res_valid got %b want 1", out_valid);
      else passed++;
      total++; if (lane_out(0) !== 4) $display("FAIL rmid_res_sum got %0d want 4", lane_out(0));
      else passed++;
      tick();
   endtask

   initial begin
      test_reset();
      test_pass();
      test_gating();
      test_accumulate();
      test_backpressure();
      test_mode_change();
      test_reset_mid_group();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
